// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin front end for a shared
//                combinational ALU. Grants one requester per cycle, feeds its
//                operands to the ALU and captures the result (or an
//                illegal-opcode error) in a single-entry response register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,

    // Requester 0
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,

    // Requester 1
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,

    // Shared combinational ALU
    output logic [3:0]  alu_op_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    input  logic [31:0] alu_data_i,

    // Response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_id_o,
    output logic        rsp_err_o
);

    // Highest legal opcode (SUB); everything above is reported as an error.
    localparam logic [3:0] C_OP_LAST_LEGAL = 4'h9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // response register empty
        ST_RESP = 1'b1    // response register holds an undelivered result
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_last_grant;
    logic [31:0] r_rsp_data;
    logic        r_rsp_id;
    logic        r_rsp_err;

    logic        w_can_accept;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_hs0;
    logic        w_hs1;
    logic        w_hs;
    logic        w_hs_id;
    logic [3:0]  w_hs_op;
    logic        w_hs_legal;

    // Round-robin grant: on contention the requester that did not win the
    // last handshake is preferred; a lone requester always gets the grant.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_grant0 = r_last_grant;
            w_grant1 = ~r_last_grant;
        end else begin
            w_grant0 = req0_valid_i;
            w_grant1 = req1_valid_i;
        end
    end

    // A new operation can be taken when the response slot is empty or is
    // being drained in this same cycle. Reset suppresses all acceptance.
    assign w_can_accept = (r_state == ST_IDLE) | rsp_ready_i;

    assign req0_ready_o = w_grant0 & w_can_accept & ~rst_i;
    assign req1_ready_o = w_grant1 & w_can_accept & ~rst_i;

    assign w_hs0 = req0_valid_i & req0_ready_o;
    assign w_hs1 = req1_valid_i & req1_ready_o;
    assign w_hs  = w_hs0 | w_hs1;

    // Grants are mutually exclusive, so the handshake id is simply hs1.
    assign w_hs_id    = w_hs1;
    assign w_hs_op    = w_hs1 ? req1_op_i : req0_op_i;
    assign w_hs_legal = (w_hs_op <= C_OP_LAST_LEGAL);

    // ALU operand mux: granted requester's payload, zeros when nobody holds
    // a grant so the ALU inputs do not toggle needlessly.
    always_comb begin
        alu_op_o    = 4'h0;
        operand_a_o = 32'h0;
        operand_b_o = 32'h0;
        if (w_grant0) begin
            alu_op_o    = req0_op_i;
            operand_a_o = req0_a_i;
            operand_b_o = req0_b_i;
        end else if (w_grant1) begin
            alu_op_o    = req1_op_i;
            operand_a_o = req1_a_i;
            operand_b_o = req1_b_i;
        end
    end

    // Next-state logic: any handshake fills (or refills) the response slot;
    // a drain without a refill returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i && !w_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Last-grant pointer moves only on an actual handshake. Reset value of 1
    // lets requester 0 win the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_last_grant <= w_hs_id;
        end
    end

    // Response register: captured on handshake, otherwise held. Illegal
    // opcodes ignore the ALU result and report an error with zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_data <= 32'h0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_hs) begin
            r_rsp_id   <= w_hs_id;
            r_rsp_err  <= ~w_hs_legal;
            r_rsp_data <= w_hs_legal ? alu_data_i : 32'h0;
        end
    end

    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_id_o    = r_rsp_id;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter, including a
//                behavioural model of the shared combinational ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [3:0]  req0_op = 4'h0;
    logic [31:0] req0_a = 32'h0;
    logic [31:0] req0_b = 32'h0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [3:0]  req1_op = 4'h0;
    logic [31:0] req1_a = 32'h0;
    logic [31:0] req1_b = 32'h0;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .alu_op_o     (alu_op),
        .operand_a_o  (operand_a),
        .operand_b_o  (operand_b),
        .alu_data_i   (alu_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU; illegal opcodes return a marker value that the
    // arbiter must not forward.
    always_comb begin
        case (alu_op)
            4'h0:    alu_data = operand_a + operand_b;
            4'h1:    alu_data = operand_a << operand_b[4:0];
            4'h2:    alu_data = {31'h0, $signed(operand_a) < $signed(operand_b)};
            4'h3:    alu_data = {31'h0, operand_a < operand_b};
            4'h4:    alu_data = operand_a ^ operand_b;
            4'h5:    alu_data = operand_a >> operand_b[4:0];
            4'h6:    alu_data = $unsigned($signed(operand_a) >>> operand_b[4:0]);
            4'h7:    alu_data = operand_a | operand_b;
            4'h8:    alu_data = operand_a & operand_b;
            4'h9:    alu_data = operand_a - operand_b;
            default: alu_data = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                             input logic id, input logic err);
        check({tag, ".valid"}, {31'h0, rsp_valid}, {31'h0, v});
        check({tag, ".data"},  rsp_data, d);
        check({tag, ".id"},    {31'h0, rsp_id}, {31'h0, id});
        check({tag, ".err"},   {31'h0, rsp_err}, {31'h0, err});
    endtask

    initial begin
        // Reset with req0 already valid: no ready while reset is high.
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd7;
        rsp_ready  = 1'b1;
        step();
        check("rst.ready0", {31'h0, req0_ready}, 32'h0);
        check_rsp("rst", 1'b0, 32'h0, 1'b0, 1'b0);

        // Single ADD 5+7, accepted immediately, response next cycle.
        rst = 1'b0;
        #1;
        check("add.ready0", {31'h0, req0_ready}, 32'h1);
        check("add.alu_a",  operand_a, 32'd5);
        step();
        req0_valid = 1'b0;
        check_rsp("add", 1'b1, 32'd12, 1'b0, 1'b0);
        #1;
        check("idle.alu_op", {28'h0, alu_op}, 32'h0);
        check("idle.alu_a",  operand_a, 32'h0);
        check("idle.alu_b",  operand_b, 32'h0);
        step();
        check("drain.valid", {31'h0, rsp_valid}, 32'h0);

        // Contention after reset: grants alternate starting with req0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h9; req0_a = 32'd10;         req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'h2; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr.ready0", {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check("rr.ready1", {31'h0, req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
            step();
            if (i % 2 == 0) check_rsp("rr.sub", 1'b1, 32'd7, 1'b0, 1'b0);
            else            check_rsp("rr.slt", 1'b1, 32'd1, 1'b1, 1'b0);
        end

        // Backpressure: response held while consumer stalls.
        req1_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd7;
        rsp_ready  = 1'b1;
        step();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_op = 4'h4; req1_a = 32'hF0; req1_b = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.ready1", {31'h0, req1_ready}, 32'h0);
            step();
            check_rsp("bp.hold", 1'b1, 32'd12, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release", {31'h0, req1_ready}, 32'h1);
        step();
        req1_valid = 1'b0;
        check_rsp("bp.xor", 1'b1, 32'h0F, 1'b1, 1'b0);
        step();
        check("bp.empty", {31'h0, rsp_valid}, 32'h0);

        // Illegal opcode, then a legal SRA, then the lowest illegal opcode.
        req0_valid = 1'b1; req0_op = 4'hC; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        check("ill.ready0", {31'h0, req0_ready}, 32'h1);
        step();
        req0_op = 4'h6; req0_a = 32'h8000_0000; req0_b = 32'd4;
        check_rsp("ill.C", 1'b1, 32'h0, 1'b0, 1'b1);
        step();
        req0_op = 4'hA; req0_a = 32'd2; req0_b = 32'd2;
        check_rsp("sra", 1'b1, 32'hF800_0000, 1'b0, 1'b0);
        step();
        req0_valid = 1'b0;
        check_rsp("ill.A", 1'b1, 32'h0, 1'b0, 1'b1);

        // Reset while a response is pending and both requesters wait.
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'h7; req1_a = 32'd3; req1_b = 32'd4;
        #1;
        check("mr.stall0", {31'h0, req0_ready}, 32'h0);
        rst = 1'b1;
        #1;
        check("mr.rst0", {31'h0, req0_ready}, 32'h0);
        check("mr.rst1", {31'h0, req1_ready}, 32'h0);
        step();
        check_rsp("mr", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mr.first0", {31'h0, req0_ready}, 32'h1);
        check("mr.first1", {31'h0, req1_ready}, 32'h0);
        step();
        check_rsp("mr.add", 1'b1, 32'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
